// File: rtl/pmixer_if.sv
`default_nettype none
// =============================================================================
// pmixer_if : reference clock, phase code and mixed-clock outputs of pmixer
// Revision  : 1.0
// =============================================================================
interface pmixer_if #(
  parameter int CODE_W = 8
);
  logic              clk_in;
  logic [CODE_W-1:0] code;
  logic              pmix_clk;
  logic              pmix_clk_90;
  logic              pmix_clk_n;
  logic              pmix_clk_90_n;

  modport master (
    output clk_in,
    output code,
    input  pmix_clk,
    input  pmix_clk_90,
    input  pmix_clk_n,
    input  pmix_clk_90_n
  );

  modport slave (
    input  clk_in,
    input  code,
    output pmix_clk,
    output pmix_clk_90,
    output pmix_clk_n,
    output pmix_clk_90_n
  );
endinterface
`default_nettype wire

// File: rtl/pmixer.sv
`default_nettype none
// =============================================================================
// pmixer   : oversampling phase mixer, reproduces clk_in delayed by code steps
// Revision : 1.0
// =============================================================================
module pmixer #(
  parameter int CODE_W  = 8,
  parameter int QUARTER = 64,
  parameter int DEPTH   = 320
) (
  input  wire logic clk,
  input  wire logic rst_n,
  pmixer_if.slave   bus
);
  localparam int IDX_W = $clog2(DEPTH);

  logic              sync1_q;
  logic              sync2_q;
  logic [DEPTH-1:0]  sr_q;
  logic [DEPTH-1:0]  sr_d;
  logic [CODE_W-1:0] code_q;
  logic [IDX_W-1:0]  tap_idx;
  logic [IDX_W-1:0]  tap90_idx;
  logic              pmix_q;
  logic              pmix_90_q;
  logic              pmix_n_q;
  logic              pmix_90_n_q;

  assign sr_d      = {sr_q[DEPTH-2:0], sync2_q};
  // Widened before the add so code+QUARTER reaches the last tap without wrapping.
  assign tap_idx   = IDX_W'(code_q);
  assign tap90_idx = IDX_W'(code_q) + IDX_W'(QUARTER);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sr_q        <= '0;
      code_q      <= '0;
      pmix_q      <= 1'b0;
      pmix_90_q   <= 1'b0;
      pmix_n_q    <= 1'b1;
      pmix_90_n_q <= 1'b1;
    end else begin
      sync1_q     <= bus.clk_in;
      sync2_q     <= sync1_q;
      sr_q        <= sr_d;
      code_q      <= bus.code;
      pmix_q      <= sr_q[tap_idx];
      pmix_90_q   <= sr_q[tap90_idx];
      pmix_n_q    <= ~sr_q[tap_idx];
      pmix_90_n_q <= ~sr_q[tap90_idx];
    end
  end

  assign bus.pmix_clk      = pmix_q;
  assign bus.pmix_clk_90   = pmix_90_q;
  assign bus.pmix_clk_n    = pmix_n_q;
  assign bus.pmix_clk_90_n = pmix_90_n_q;
endmodule
`default_nettype wire

// File: tb/tb_pmixer.sv
`default_nettype none
// =============================================================================
// tb_pmixer : randomized bench comparing pmixer against a sample-history model
// Revision  : 1.0
// =============================================================================
module tb_pmixer;
  localparam int CODE_W  = 8;
  localparam int QUARTER = 64;
  localparam int DEPTH   = 320;
  localparam int HIST    = 65536;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  pmixer_if #(.CODE_W(CODE_W)) bus ();

  pmixer #(
    .CODE_W (CODE_W),
    .QUARTER(QUARTER),
    .DEPTH  (DEPTH)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n      = 0;
  bit x_hist [HIST];
  int c_hist [HIST];
  int hi_len = 128;
  int lo_len = 129;
  int ph_cnt = 0;
  bit stuck  = 1'b0;

  task automatic check(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", tag, got, exp, n);
    end
  endtask

  // Output after edge n is the clk_in level sampled 3 + code + extra edges
  // earlier, where code is the value presented at the previous edge.
  function automatic logic ref_tap(input int extra);
    int cprev;
    int idx;
    cprev = (n >= 1) ? c_hist[n-1] : 0;
    idx   = n - 3 - cprev - extra;
    return (idx < 0) ? 1'b0 : x_hist[idx];
  endfunction

  task automatic gen_clkin();
    if (!stuck) begin
      ph_cnt++;
      if (bus.clk_in && ph_cnt >= hi_len) begin
        bus.clk_in = 1'b0;
        ph_cnt     = 0;
      end else if (!bus.clk_in && ph_cnt >= lo_len) begin
        bus.clk_in = 1'b1;
        ph_cnt     = 0;
        hi_len     = $urandom_range(127, 129);
        lo_len     = 257 - hi_len;
      end
    end
  endtask

  task automatic tick();
    logic e0;
    logic e90;
    @(posedge clk);
    x_hist[n] = bus.clk_in;
    c_hist[n] = int'(bus.code);
    #2;
    e0  = ref_tap(0);
    e90 = ref_tap(QUARTER);
    check("pmix_clk",      bus.pmix_clk,      e0);
    check("pmix_clk_90",   bus.pmix_clk_90,   e90);
    check("pmix_clk_n",    bus.pmix_clk_n,    ~e0);
    check("pmix_clk_90_n", bus.pmix_clk_90_n, ~e90);
    n++;
    @(negedge clk);
    gen_clkin();
  endtask

  task automatic check_reset_outputs();
    check("rst_pmix_clk",      bus.pmix_clk,      1'b0);
    check("rst_pmix_clk_90",   bus.pmix_clk_90,   1'b0);
    check("rst_pmix_clk_n",    bus.pmix_clk_n,    1'b1);
    check("rst_pmix_clk_90_n", bus.pmix_clk_90_n, 1'b1);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #2;
      check_reset_outputs();
      @(negedge clk);
      bus.clk_in = 1'($urandom_range(0, 1));
      bus.code   = CODE_W'($urandom_range(0, 255));
    end
    bus.clk_in = 1'b0;
    ph_cnt     = 0;
    stuck      = 1'b0;
    n          = 0;
    rst_n      = 1'b1;
  endtask

  initial begin
    int waited;
    bus.clk_in = 1'b0;
    bus.code   = '0;
    do_reset(8);

    bus.code = 8'd0;
    repeat (800) tick();
    bus.code = 8'd255;
    repeat (800) tick();

    // Step 10 -> 200 while pmix_clk is high
    bus.code = 8'd10;
    repeat (600) tick();
    waited = 0;
    while (bus.pmix_clk !== 1'b1 && waited < 600) begin
      tick();
      waited++;
    end
    check("wait_pmix_high", (waited < 600), 1'b1);
    repeat (20) tick();
    bus.code = 8'd200;
    repeat (800) tick();

    for (int k = 0; k < 40; k++) begin
      bus.code = CODE_W'($urandom_range(0, 255));
      repeat (520) tick();
    end

    repeat (1500) begin
      bus.code = CODE_W'($urandom_range(0, 255));
      tick();
    end

    stuck      = 1'b1;
    bus.clk_in = 1'b1;
    bus.code   = 8'd255;
    repeat (DEPTH + 10) tick();
    check("stuck_hi_90", bus.pmix_clk_90, 1'b1);
    check("stuck_hi_0",  bus.pmix_clk,    1'b1);
    bus.clk_in = 1'b0;
    repeat (DEPTH + 10) tick();
    check("stuck_lo_90", bus.pmix_clk_90, 1'b0);
    check("stuck_lo_0",  bus.pmix_clk,    1'b0);
    stuck = 1'b0;

    repeat (300) tick();
    do_reset(5);
    bus.code = CODE_W'($urandom_range(0, 255));
    repeat (900) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1);
  end
endmodule
`default_nettype wire
